iir_seq: RTL and testbench

Parametrised, time-multiplexed IIR filter with decimation for the FM-radio datapath. It pops samples from an upstream FIFO and keeps x and y histories of depth TAPS. On each decimated output it evaluates the difference equation with a single multiply–dequantize unit, one product per cycle, then pushes the result to a downstream FIFO. It replaces fixed two-tap, fully parallel IIR stages (de-emphasis and similar) where tap count, quantization and area must scale.

---
 rtl/iir_pkg.sv | 35 +++
 rtl/iir_seq_dequant_mul.sv | 29 ++
 rtl/iir_seq.sv | 143 ++++++++++++++
 tb/tb_iir_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed IIR filter.
//   - iir_state_e : controller states (idle/pop, multiply-accumulate, write-out)
//   - dq()        : dequantise a full-width signed product (shift toward zero)
//   - DefXCoeffs / DefYCoeffs : default two-tap de-emphasis coefficients
package iir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite
    } iir_state_e;

    // Working width for dq(); wide enough for a 64x64 product.
    localparam int unsigned DqWidth = 128;

    // Element [k] holds coefficient k (element 0 is the rightmost word).
    localparam logic [1:0][31:0] DefXCoeffs = {32'h0000_00B2, 32'h0000_00B2};
    // a[0] is never used; a[1] = -666.
    localparam logic [1:0][31:0] DefYCoeffs = {32'hFFFF_FD66, 32'h0000_0000};

    // Arithmetic right shift by quant_bits, rounding toward zero rather than
    // toward minus infinity: negative products are shifted as magnitudes.
    function automatic logic signed [DqWidth-1:0] dq(
        input logic signed [DqWidth-1:0] p,
        input int unsigned               quant_bits
    );
        logic signed [DqWidth-1:0] mag;
        if (p < 0) begin
            mag = -p;
            return -(mag >> quant_bits);
        end
        return p >>> quant_bits;
    endfunction

endpackage

// File: rtl/iir_seq_dequant_mul.sv
// Combinational signed multiply followed by dequantisation.
//   coeff  : signed coefficient, DATA_SIZE bits
//   sample : signed history sample, DATA_SIZE bits
//   result : dq(coeff * sample) truncated to DATA_SIZE bits
module dequant_mul #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned QUANT_BITS = 10
) (
    input  logic [DATA_SIZE-1:0] coeff,
    input  logic [DATA_SIZE-1:0] sample,
    output logic [DATA_SIZE-1:0] result
);
    import iir_pkg::*;

    logic signed [2*DATA_SIZE-1:0] prod;
    logic signed [DqWidth-1:0]     prod_ext;
    logic signed [DqWidth-1:0]     dq_full;
    logic                          unused_dq_msbs;

    // Sign-extend both operands first so the full double-width product is kept.
    assign prod     = (2*DATA_SIZE)'($signed(coeff)) * (2*DATA_SIZE)'($signed(sample));
    assign prod_ext = DqWidth'(prod);
    assign dq_full  = dq(prod_ext, QUANT_BITS);
    assign result   = dq_full[DATA_SIZE-1:0];

    // Bits above DATA_SIZE are discarded: the result wraps by design.
    assign unused_dq_msbs = ^dq_full[DqWidth-1:DATA_SIZE];

endmodule

// File: rtl/iir_seq.sv
// Time-multiplexed IIR filter with decimation.
// Pops samples from an upstream FIFO, and once every DECIMATION pops evaluates
//   y = sum_k dq(b[k]*xh[k]) + sum_{k>=1} dq(a[k]*yh[k-1])
// one product per cycle on a single dequant_mul, then pushes y downstream.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   x_in, x_empty, x_rd_en   : upstream FIFO head / empty / pop
//   y_out, y_out_full, y_wr_en : downstream FIFO data / full / push
module iir_seq
    import iir_pkg::*;
#(
    parameter int unsigned                         TAPS       = 2,
    parameter int unsigned                         DECIMATION = 1,
    parameter int unsigned                         DATA_SIZE  = 32,
    parameter int unsigned                         QUANT_BITS = 10,
    parameter logic [TAPS-1:0][DATA_SIZE-1:0] X_COEFFS   = DefXCoeffs,
    parameter logic [TAPS-1:0][DATA_SIZE-1:0] Y_COEFFS   = DefYCoeffs
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] x_in,
    input  logic                 x_empty,
    output logic                 x_rd_en,
    output logic [DATA_SIZE-1:0] y_out,
    input  logic                 y_out_full,
    output logic                 y_wr_en
);

    localparam int unsigned   CntW     = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int unsigned   NumTerms = 2 * TAPS - 1;
    localparam int unsigned   IdxW     = $clog2(NumTerms);
    localparam logic [CntW-1:0] CntLast = CntW'(DECIMATION - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumTerms - 1);

    iir_state_e                    state_q, state_d;
    logic [TAPS-1:0][DATA_SIZE-1:0] xh_q, xh_d;
    logic [TAPS-1:0][DATA_SIZE-1:0] yh_q, yh_d;
    logic [DATA_SIZE-1:0]          acc_q, acc_d;
    logic [DATA_SIZE-1:0]          y_out_q, y_out_d;
    logic [CntW-1:0]               count_q, count_d;
    logic [IdxW-1:0]               idx_q, idx_d;

    logic [DATA_SIZE-1:0] coeff_sel;
    logic [DATA_SIZE-1:0] sample_sel;
    logic [DATA_SIZE-1:0] term;

    // Term i < TAPS is b[i]*xh[i]; later terms walk a[1..] against yh[0..].
    always_comb begin
        coeff_sel  = '0;
        sample_sel = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (idx_q == IdxW'(k)) begin
                coeff_sel  = X_COEFFS[k];
                sample_sel = xh_q[k];
            end
        end
        for (int k = 1; k < TAPS; k++) begin
            if (idx_q == IdxW'(TAPS + k - 1)) begin
                coeff_sel  = Y_COEFFS[k];
                sample_sel = yh_q[k-1];
            end
        end
    end

    dequant_mul #(
        .DATA_SIZE  (DATA_SIZE),
        .QUANT_BITS (QUANT_BITS)
    ) u_dequant_mul (
        .coeff  (coeff_sel),
        .sample (sample_sel),
        .result (term)
    );

    always_comb begin
        state_d = state_q;
        xh_d    = xh_q;
        yh_d    = yh_q;
        acc_d   = acc_q;
        y_out_d = y_out_q;
        count_d = count_q;
        idx_d   = idx_q;
        x_rd_en = 1'b0;
        y_wr_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Reset forces the state to idle immediately; keep the pop off until released.
                if (!x_empty && !reset) begin
                    x_rd_en = 1'b1;
                    xh_d    = {xh_q[TAPS-2:0], x_in};
                    if (count_q == CntLast) begin
                        count_d = '0;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = StMac;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StMac: begin
                acc_d = acc_q + term;
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    y_out_d = acc_q + term;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Feedback history only advances on an accepted write.
                if (!y_out_full) begin
                    y_wr_en = 1'b1;
                    yh_d    = {yh_q[TAPS-2:0], acc_q};
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            xh_q    <= '0;
            yh_q    <= '0;
            acc_q   <= '0;
            y_out_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            xh_q    <= xh_d;
            yh_q    <= yh_d;
            acc_q   <= acc_d;
            y_out_q <= y_out_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    assign y_out = y_out_q;

endmodule

// File: tb/tb_iir_seq.sv
// Bench for iir_seq: two instances (defaults, and a decimate-by-4 variant)
// driven from bench-side FIFOs with random gaps and backpressure, checked
// cycle by cycle against a difference-equation model over full histories.
module tb_iir_seq;

    localparam int Taps = 2;
    localparam int Qb   = 10;

    logic        clock = 1'b0;
    logic        rst_s     [2];
    logic [31:0] x_in_s    [2];
    logic        x_empty_s [2];
    logic        full_s    [2];

    logic        rd_a, rd_b, wr_a, wr_b;
    logic [31:0] y_a, y_b;

    always #5 clock = ~clock;

    iir_seq u_dut_a (
        .clock      (clock),
        .reset      (rst_s[0]),
        .x_in       (x_in_s[0]),
        .x_empty    (x_empty_s[0]),
        .x_rd_en    (rd_a),
        .y_out      (y_a),
        .y_out_full (full_s[0]),
        .y_wr_en    (wr_a)
    );

    iir_seq #(
        .TAPS       (2),
        .DECIMATION (4),
        .DATA_SIZE  (32),
        .QUANT_BITS (10),
        .X_COEFFS   ({32'h0000_0300, 32'h0000_0001}),
        .Y_COEFFS   ({32'hFFFF_FE00, 32'h0000_0000})
    ) u_dut_b (
        .clock      (clock),
        .reset      (rst_s[1]),
        .x_in       (x_in_s[1]),
        .x_empty    (x_empty_s[1]),
        .x_rd_en    (rd_b),
        .y_out      (y_b),
        .y_out_full (full_s[1]),
        .y_wr_en    (wr_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int bco [2][Taps];
    int aco [2][Taps];
    int decs[2];

    int src_mem [2][256];
    int src_len [2];
    int src_pos [2];
    int gap_pct [2];
    int full_pct[2];
    int rst_cmd [2];
    bit arm_rst [2];
    bit bp_hold [2];
    int wlog    [2][256];
    int wcnt    [2];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Integer division truncates toward zero, which is exactly the rounding wanted.
    function automatic int dq(input longint p);
        longint d;
        d = p / (longint'(1) << Qb);
        return int'(d);
    endfunction

    task automatic push(input int ch, input int val);
        src_mem[ch][src_len[ch]] = val;
        src_len[ch]++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic wait_writes(input int ch, input int target, input int budget,
                               input string name);
        int n = 0;
        while (wcnt[ch] < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        check(name, wcnt[ch] >= target, 1);
    endtask

    // Drives one channel's inputs after each rising edge and checks its outputs
    // at the falling edge against the timing and arithmetic the filter must obey.
    task automatic run_chan(input int ch);
        int c = 0, due = 0, pop_c = 0, pops = 0, full_left = 0, rst_left = 0;
        int pend_y = 0, last_y = 0, act_y;
        bit busy = 0, popped = 0, exp_rd, exp_wr, act_rd, act_wr, avail;
        int xh[$];
        int yh[$];
        forever begin
            @(posedge clock);
            #1;
            c++;
            if (popped) src_pos[ch]++;
            popped = 0;
            if (rst_cmd[ch] > 0) begin
                rst_left    = rst_cmd[ch];
                rst_cmd[ch] = 0;
            end
            if (arm_rst[ch] && busy && c == pop_c + 2) begin
                rst_left    = 2;
                arm_rst[ch] = 0;
            end
            rst_s[ch] = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            if (bp_hold[ch] && busy && c == due) begin
                full_left   = 5;
                bp_hold[ch] = 0;
            end
            if (full_left > 0) begin
                full_s[ch] = 1'b1;
                full_left--;
            end else begin
                full_s[ch] = ($urandom_range(99) < full_pct[ch]);
            end
            avail         = src_pos[ch] < src_len[ch];
            x_empty_s[ch] = !avail || ($urandom_range(99) < gap_pct[ch]);
            x_in_s[ch]    = avail ? src_mem[ch][src_pos[ch]] : $urandom;

            @(negedge clock);
            act_rd = (ch == 0) ? rd_a : rd_b;
            act_wr = (ch == 0) ? wr_a : wr_b;
            act_y  = (ch == 0) ? int'(y_a) : int'(y_b);
            if (rst_s[ch]) begin
                busy   = 0;
                pops   = 0;
                last_y = 0;
                xh.delete();
                yh.delete();
                check("reset x_rd_en", act_rd, 0);
                check("reset y_wr_en", act_wr, 0);
                check("reset y_out", act_y, 0);
            end else begin
                exp_rd = !busy && !x_empty_s[ch];
                exp_wr = busy && c >= due && !full_s[ch];
                check(ch == 0 ? "a x_rd_en" : "b x_rd_en", act_rd, exp_rd);
                check(ch == 0 ? "a y_wr_en" : "b y_wr_en", act_wr, exp_wr);
                if (busy && c >= due) check(ch == 0 ? "a y_out" : "b y_out", act_y, pend_y);
                else check(ch == 0 ? "a y_out hold" : "b y_out hold", act_y, last_y);
                if (exp_rd) begin
                    popped = 1;
                    xh.push_front(int'(x_in_s[ch]));
                    pops++;
                    if (pops == decs[ch]) begin
                        pops   = 0;
                        pend_y = 0;
                        for (int k = 0; k < Taps; k++)
                            pend_y += dq(longint'(bco[ch][k]) *
                                         longint'((k < xh.size()) ? xh[k] : 0));
                        for (int k = 1; k < Taps; k++)
                            pend_y += dq(longint'(aco[ch][k]) *
                                         longint'((k - 1 < yh.size()) ? yh[k-1] : 0));
                        busy  = 1;
                        pop_c = c;
                        due   = c + 2 * Taps;
                    end
                end
                if (exp_wr) begin
                    yh.push_front(pend_y);
                    last_y               = pend_y;
                    wlog[ch][wcnt[ch]]   = pend_y;
                    wcnt[ch]++;
                    busy = 0;
                end
            end
        end
    endtask

    task automatic stim_a();
        int base;
        wait_cycles(6);
        // Impulse response.
        push(0, 1024);
        repeat (15) push(0, 0);
        wait_writes(0, 16, 400, "impulse writes");
        check("impulse y0", wlog[0][0], 178);
        check("impulse y1", wlog[0][1], 63);
        check("impulse y2", wlog[0][2], -40);
        check("impulse y3", wlog[0][3], 26);
        // Five-cycle backpressure on the first write of this batch.
        base       = wcnt[0];
        bp_hold[0] = 1;
        repeat (4) push(0, int'($urandom_range(4000)) - 2000);
        wait_writes(0, base + 4, 200, "backpressure writes");
        // Random data with random gaps and random backpressure.
        base        = wcnt[0];
        gap_pct[0]  = 40;
        full_pct[0] = 20;
        repeat (100) push(0, int'($urandom));
        wait_writes(0, base + 100, 4000, "random writes");
        // Reset during the second MAC cycle discards the pending result.
        gap_pct[0]  = 0;
        full_pct[0] = 0;
        wait_cycles(10);
        base       = wcnt[0];
        arm_rst[0] = 1;
        push(0, 5000);
        wait_cycles(30);
        check("reset fired", arm_rst[0], 0);
        check("no write after reset", wcnt[0], base);
        push(0, 1024);
        push(0, 0);
        push(0, 0);
        wait_writes(0, base + 3, 200, "post-reset writes");
        check("post-reset y0", wlog[0][base], 178);
        check("post-reset y1", wlog[0][base + 1], 63);
    endtask

    task automatic stim_b();
        int base;
        wait_cycles(6);
        push(1, 0); push(1, 0); push(1, 0); push(1, -1);
        push(1, 0); push(1, 0); push(1, 0); push(1, -2048);
        wait_writes(1, 2, 200, "rounding writes");
        check("round -1", wlog[1][0], 0);
        check("round -2048", wlog[1][1], -2);
        base        = wcnt[1];
        gap_pct[1]  = 30;
        full_pct[1] = 15;
        repeat (16) push(1, int'($urandom));
        wait_writes(1, base + 4, 600, "decimation writes");
        wait_cycles(40);
        check("decimation write count", wcnt[1] - base, 4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bco[0] = '{178, 178};
        aco[0] = '{0, -666};
        bco[1] = '{1, 32'h300};
        aco[1] = '{0, -512};
        decs   = '{1, 4};
        for (int ch = 0; ch < 2; ch++) begin
            rst_s[ch]     = 1'b1;
            x_in_s[ch]    = '0;
            x_empty_s[ch] = 1'b1;
            full_s[ch]    = 1'b0;
            src_len[ch]   = 0;
            src_pos[ch]   = 0;
            gap_pct[ch]   = 0;
            full_pct[ch]  = 0;
            rst_cmd[ch]   = 3;
            arm_rst[ch]   = 0;
            bp_hold[ch]   = 0;
            wcnt[ch]      = 0;
        end
        fork
            run_chan(0);
            run_chan(1);
        join_none
        fork
            stim_a();
            stim_b();
        join
        wait_cycles(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
